// File: rtl/delay_sum_reader_pkg.sv
// delay_sum_reader_pkg
// Shared definitions for the delay-and-sum beamformer path: array geometry,
// delay index width, the reader FSM state type and the packed per-microphone
// delay array that the delta generator also produces.
package delay_sum_reader_pkg;

  localparam int N_MIC     = 16;
  localparam int DELTA_W   = 8;
  localparam int DELTA_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Index m = microphone m, identical ordering to the delta generator output.
  typedef logic [N_MIC-1:0][DELTA_W-1:0] delta_arr_t;

endpackage

// File: rtl/delay_sum_reader_sample_bank.sv
// delay_sum_reader_sample_bank
// Per-microphone circular sample buffer: simple dual-port RAM with one write
// port and one registered read port. A read and write to the same address in
// the same cycle returns the previous contents.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data (one sample)
//   i_raddr  read address, data appears on o_rdata the next cycle
//   o_rdata  registered read data
module delay_sum_reader_sample_bank #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 512,
  parameter int AW       = 9
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [SAMPLE_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/delay_sum_reader.sv
// delay_sum_reader
// Buffers 16 microphone streams in circular RAMs and, per pixel, reads each
// buffer back at its own delay, sums the aligned samples, squares the sum and
// accumulates N_FRAME steps into one beamformed power value.
// Optional feature: define DELAY_SUM_SATURATE_EN to make the accumulator
// saturate at 2^ACC_W-1 instead of wrapping.
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_sample_valid    write one sample per microphone this cycle
//   i_sample          16 signed samples, index m = microphone m
//   i_start           start one pixel (accepted only when o_ready=1)
//   i_delta           16 x 8-bit per-microphone delays
//   o_ready           high while idle
//   o_valid           one-cycle pulse, o_power valid
//   o_power           accumulated power, held until the next o_valid
//   o_overrun         buffer-overwrite hazard during the last pixel
module delay_sum_reader
  import delay_sum_reader_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 512,
  parameter int N_FRAME  = 64,
  parameter int ACC_W    = 46
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_sample_valid,
  input  logic [N_MIC-1:0][SAMPLE_W-1:0]  i_sample,
  input  logic                            i_start,
  input  logic [N_MIC-1:0][DELTA_W-1:0]   i_delta,
  output logic                            o_ready,
  output logic                            o_valid,
  output logic [ACC_W-1:0]                o_power,
  output logic                            o_overrun
);

  localparam int AW     = $clog2(DEPTH);
  localparam int SUM_W  = SAMPLE_W + 4;
  localparam int SQ_W   = 2 * SUM_W;
  localparam int CNT_W  = $clog2(N_FRAME + 3);
  localparam int WCNT_W = $clog2(N_FRAME + 5) + 1;
  // Writes beyond this many during one busy period can reach the oldest
  // sample still to be read.
  localparam int THRESH = DEPTH - N_FRAME - DELTA_MAX - 1;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_base;
  delta_arr_t         r_delta;
  logic               w_accept;

  logic [N_MIC-1:0][AW-1:0]       w_raddr;
  logic [N_MIC-1:0][SAMPLE_W-1:0] w_rdata;

  logic                    r_v_rd, r_v_sum, r_v_sq;
  logic signed [SUM_W-1:0] w_sum, r_sum;
  logic signed [SQ_W-1:0]  w_sum_ext, w_sq;
  logic [SQ_W-1:0]         r_sq;
  logic [ACC_W-1:0]        r_acc, w_acc_next, w_sq_ext;
  logic [ACC_W-1:0]        r_power;

  logic [WCNT_W-1:0] r_wcnt;
  logic              r_overrun;
  logic              w_ovr_now;

  assign o_ready  = (r_state == ST_IDLE);
  assign o_valid  = (r_state == ST_DONE);
  assign w_accept = i_start && o_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(N_FRAME - 1)) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == CNT_W'(2)) begin
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- write pointer and pixel snapshot ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp    <= '0;
      r_base  <= '0;
      r_delta <= '0;
    end else begin
      if (i_sample_valid) begin
        r_wp <= r_wp + AW'(1);
      end
      // r_wp here is the pre-write pointer, so a same-cycle write is excluded.
      if (w_accept) begin
        r_base  <= r_wp - AW'(1);
        r_delta <= i_delta;
      end
    end
  end

  // ---------------- sample banks ----------------
  for (genvar gi = 0; gi < N_MIC; gi++) begin : g_bank
    assign w_raddr[gi] = r_base - AW'(r_cnt) - AW'(r_delta[gi]);

    delay_sum_reader_sample_bank #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH),
      .AW       (AW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (i_sample_valid),
      .i_waddr (r_wp),
      .i_wdata (i_sample[gi]),
      .i_raddr (w_raddr[gi]),
      .o_rdata (w_rdata[gi])
    );
  end

  // ---------------- sum / square / accumulate ----------------
  always_comb begin
    w_sum = '0;
    for (int m = 0; m < N_MIC; m++) begin
      w_sum = w_sum + SUM_W'($signed(w_rdata[m]));
    end
  end

  assign w_sum_ext = SQ_W'(r_sum);
  assign w_sq      = w_sum_ext * w_sum_ext;
  assign w_sq_ext  = ACC_W'(r_sq);

`ifdef DELAY_SUM_SATURATE_EN
  logic [ACC_W:0] w_acc_sum;
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_sq_ext};
  // Addends are non-negative, so once saturated the result stays saturated.
  assign w_acc_next = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
`else
  assign w_acc_next = r_acc + w_sq_ext;
`endif

  always_ff @(posedge i_clk) begin
    r_sum <= w_sum;
    r_sq  <= w_sq;
    if (!i_rst_n) begin
      r_v_rd  <= 1'b0;
      r_v_sum <= 1'b0;
      r_v_sq  <= 1'b0;
      r_acc   <= '0;
      r_power <= '0;
    end else begin
      r_v_rd  <= (r_state == ST_RUN);
      r_v_sum <= r_v_rd;
      r_v_sq  <= r_v_sum;
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_v_sq) begin
        r_acc <= w_acc_next;
      end
      if (r_state == ST_DONE) begin
        r_power <= r_acc;
      end
    end
  end

  // ---------------- overrun tracking ----------------
  // The DONE cycle's own write still counts as a busy-period write.
  assign w_ovr_now = (int'(r_wcnt) + int'(i_sample_valid)) > THRESH;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wcnt    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcnt    <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (i_sample_valid && !o_ready) begin
          r_wcnt <= r_wcnt + WCNT_W'(1);
        end
        if (r_state == ST_DONE) begin
          r_overrun <= w_ovr_now;
        end
      end
    end
  end

  // Power and overrun become visible in the DONE cycle itself.
  assign o_power   = (r_state == ST_DONE) ? r_acc : r_power;
  assign o_overrun = (r_state == ST_DONE) ? w_ovr_now : r_overrun;

endmodule

// File: tb/tb_delay_sum_reader.sv
module tb_delay_sum_reader;

  localparam int NF_A = 64,  DP_A = 512,  AW_A = 46;
  localparam int NF_B = 576, DP_B = 1024, AW_B = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, sv, st;
  logic [15:0][15:0] smp [2];
  logic [15:0][7:0]  dl  [2];
  logic rdy_a, rdy_b, vld_a, vld_b, ovr_a, ovr_b;
  logic [AW_A-1:0] pwr_a;
  logic [AW_B-1:0] pwr_b;
  wire  [1:0] rdy = {rdy_b, rdy_a};
  wire  [1:0] vld = {vld_b, vld_a};
  wire  [1:0] ovr = {ovr_b, ovr_a};

  delay_sum_reader #(.SAMPLE_W(16), .DEPTH(DP_A), .N_FRAME(NF_A), .ACC_W(AW_A)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_sample_valid(sv[0]), .i_sample(smp[0]),
    .i_start(st[0]), .i_delta(dl[0]), .o_ready(rdy_a), .o_valid(vld_a),
    .o_power(pwr_a), .o_overrun(ovr_a));

  delay_sum_reader #(.SAMPLE_W(16), .DEPTH(DP_B), .N_FRAME(NF_B), .ACC_W(AW_B)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_sample_valid(sv[1]), .i_sample(smp[1]),
    .i_start(st[1]), .i_delta(dl[1]), .o_ready(rdy_b), .o_valid(vld_b),
    .o_power(pwr_b), .o_overrun(ovr_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nf(int k); return (k == 0) ? NF_A : NF_B; endfunction
  function automatic int dp(int k); return (k == 0) ? DP_A : DP_B; endfunction
  function automatic int aw(int k); return (k == 0) ? AW_A : AW_B; endfunction
  function automatic logic [63:0] get_pwr(int k);
    return (k == 0) ? 64'(pwr_a) : 64'(pwr_b);
  endfunction

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got=%0d want=%0d", nm, k, act, exp);
    end
  endtask

  // Reduce the exact (unbounded) power to the accumulator's behaviour.
  function automatic logic [63:0] final_pow(int k, longint a);
    logic [63:0] lim;
    lim = (64'd1 << aw(k)) - 64'd1;
`ifdef DELAY_SUM_SATURATE_EN
    return (64'(a) > lim) ? lim : 64'(a);
`else
    return 64'(a) & lim;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  int          m_mem [2][1024][16];
  int          m_wp [2], m_base [2], m_cur [2], m_wcnt [2];
  bit          m_busy [2];
  bit          m_ovr [2];
  longint      m_acc [2];
  logic [63:0] m_pow [2];
  logic [15:0][7:0] m_dl [2];

  always @(posedge clk) begin
    int s;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        m_wp[k] = 0; m_busy[k] = 0; m_pow[k] = 0; m_ovr[k] = 0;
      end else begin
        if (m_busy[k]) begin
          // step t read during cycle t+1 sees memory before this edge's write
          if (m_cur[k] >= 1 && m_cur[k] <= nf(k)) begin
            s = 0;
            for (int m = 0; m < 16; m++)
              s += m_mem[k][(m_base[k] - (m_cur[k] - 1) - int'(m_dl[k][m])) & (dp(k) - 1)][m];
            m_acc[k] += longint'(s) * longint'(s);
          end
          if (sv[k]) m_wcnt[k]++;
          if (m_cur[k] == nf(k) + 4) begin
            m_busy[k] = 0;
            m_pow[k]  = final_pow(k, m_acc[k]);
            m_ovr[k]  = m_wcnt[k] > (dp(k) - nf(k) - 256);
          end
          m_cur[k]++;
        end else if (st[k]) begin
          m_busy[k] = 1; m_base[k] = (m_wp[k] - 1) & (dp(k) - 1);
          m_dl[k] = dl[k]; m_acc[k] = 0; m_wcnt[k] = 0; m_cur[k] = 1; m_ovr[k] = 0;
        end
        if (sv[k]) begin
          for (int m = 0; m < 16; m++) m_mem[k][m_wp[k]][m] = int'($signed(smp[k][m]));
          m_wp[k] = (m_wp[k] + 1) & (dp(k) - 1);
        end
      end
    end
  end

  int          vcount [2] = '{0, 0};
  int          vcyc [2];
  logic [63:0] last_pow [2];
  logic        last_ovr [2];

  always @(negedge clk) begin
    bit ev, eo;
    logic [63:0] ep;
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        ev = m_busy[k] && (m_cur[k] == nf(k) + 4);
        ep = ev ? final_pow(k, m_acc[k]) : m_pow[k];
        eo = ev ? ((m_wcnt[k] + (sv[k] ? 1 : 0)) > (dp(k) - nf(k) - 256)) : m_ovr[k];
        chk("ready", k, 64'(rdy[k]), 64'(!m_busy[k]));
        chk("valid", k, 64'(vld[k]), 64'(ev));
        chk("power", k, get_pwr(k), ep);
        chk("overrun", k, 64'(ovr[k]), 64'(eo));
        if (vld[k]) begin
          vcount[k]++;
          vcyc[k]     = cyc;
          last_pow[k] = get_pwr(k);
          last_ovr[k] = ovr[k];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(int k, int val);
    for (int m = 0; m < 16; m++) smp[k][m] = 16'(val);
  endtask

  task automatic fill(int k, int n, int val);
    for (int i = 0; i < n; i++) begin
      sv[k] = 1'b1; set_all(k, val); tick();
    end
    sv[k] = 1'b0;
  endtask

  task automatic rand_fill(int k, int n);
    for (int i = 0; i < n; i++) begin
      sv[k] = 1'b1;
      for (int m = 0; m < 16; m++) smp[k][m] = 16'($urandom);
      tick();
    end
    sv[k] = 1'b0;
  endtask

  // Start at cycle 0, then run to the first ready cycle; a stray start at
  // cycle 10 and scrambled deltas exercise the ignored-input rules.
  task automatic pixel(int k, logic [15:0][7:0] d, int busy_wr, int val, bit rnd,
                       bit cow, int cow_val, output int t0);
    st[k] = 1'b1; dl[k] = d; sv[k] = cow; set_all(k, cow_val); t0 = cyc;
    tick();
    for (int c = 1; c <= nf(k) + 4; c++) begin
      if (c == 1) chk("ovr_clear_on_start", k, 64'(ovr[k]), 64'd0);
      st[k] = (c == 10);
      dl[k] = {$urandom, $urandom, $urandom, $urandom};
      if (rnd) begin
        sv[k] = 1'($urandom);
        for (int m = 0; m < 16; m++) smp[k][m] = 16'($urandom);
      end else begin
        sv[k] = (c <= busy_wr);
        set_all(k, val);
      end
      tick();
    end
    st[k] = 1'b0; sv[k] = 1'b0;
  endtask

  initial begin
    int t0, v0, w0, s_end;
    logic [15:0][7:0] d;
    rst_n = 2'b00; sv = 2'b00; st = 2'b00;
    smp[0] = '0; smp[1] = '0; dl[0] = '0; dl[1] = '0;
    tick(); tick();
    rst_n = 2'b11;

    chk("rst_ready", 0, 64'(rdy_a), 64'd1);
    chk("rst_valid", 0, 64'(vld_a), 64'd0);
    chk("rst_power", 0, 64'(pwr_a), 64'd0);
    chk("rst_ovr",   0, 64'(ovr_a), 64'd0);
    chk("rst_ready", 1, 64'(rdy_b), 64'd1);
    chk("rst_power", 1, 64'(pwr_b), 64'd0);

    // constant input, with a stray start at cycle 10
    fill(0, 512, 0);
    fill(0, 320, 1);
    d = {16{8'd160}};
    v0 = vcount[0];
    pixel(0, d, 0, 0, 1'b0, 1'b0, 0, t0);
    chk("const_latency", 0, 64'(vcyc[0] - t0), 64'd68);
    chk("const_nvalid",  0, 64'(vcount[0] - v0), 64'd1);
    chk("const_power",   0, last_pow[0], 64'd16384);

    // impulse alignment, then mic 5 shifted by one sample
    for (int sh = 0; sh < 2; sh++) begin
      for (int m = 0; m < 16; m++) d[m] = 8'($urandom_range(147, 179));
      w0 = m_wp[0];
      s_end = (w0 + 400) & 511;
      for (int i = 0; i < 400; i++) begin
        for (int m = 0; m < 16; m++)
          smp[0][m] = (((w0 + i) & 511) ==
                       ((s_end - 1 - int'(d[m]) - ((sh == 1 && m == 5) ? 1 : 0)) & 511)) ? 16'd1 : 16'd0;
        sv[0] = 1'b1;
        tick();
      end
      sv[0] = 1'b0;
      pixel(0, d, 0, 0, 1'b0, 1'b0, 0, t0);
      chk(sh == 0 ? "impulse_power" : "impulse_shift_power", 0, last_pow[0],
          sh == 0 ? 64'd256 : 64'd226);
    end

    // write coincident with start is excluded
    fill(0, 512, 0);
    d = '0;
    pixel(0, d, 0, 0, 1'b0, 1'b1, 1000, t0);
    chk("write_excluded", 0, last_pow[0], 64'd0);

    // randomized pixels
    rand_fill(0, 512);
    for (int r = 0; r < 5; r++) begin
      rand_fill(0, $urandom_range(1, 40));
      d = {$urandom, $urandom, $urandom, $urandom};
      pixel(0, d, 0, 0, 1'b1, 1'($urandom), int'($urandom_range(0, 65535)), t0);
    end

    // mid-run reset at RUN step 30
    st[0] = 1'b1; dl[0] = {$urandom, $urandom, $urandom, $urandom};
    tick();
    st[0] = 1'b0;
    v0 = vcount[0];
    repeat (30) tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    chk("ready_after_reset", 0, 64'(rdy_a), 64'd1);
    repeat (80) tick();
    chk("no_valid_after_reset", 0, 64'(vcount[0] - v0), 64'd0);
    d = {$urandom, $urandom, $urandom, $urandom};
    pixel(0, d, 0, 0, 1'b1, 1'b0, 0, t0);

    // long-frame instance: full-scale samples, overrun threshold 192
    fill(1, 1024, 32767);
    d = {$urandom, $urandom, $urandom, $urandom};
    pixel(1, d, 193, 32767, 1'b0, 1'b0, 0, t0);
    chk("b_latency", 1, 64'(vcyc[1] - t0), 64'd580);
    chk("b_overrun_193", 1, 64'(last_ovr[1]), 64'd1);
`ifdef DELAY_SUM_SATURATE_EN
    chk("b_power_sat", 1, last_pow[1], 64'd1099511627775);
`else
    chk("b_power_wrap", 1, last_pow[1], 64'd1089848098816);
`endif
    chk("b_overrun_held", 1, 64'(ovr_b), 64'd1);
    pixel(1, d, 192, 32767, 1'b0, 1'b0, 0, t0);
    chk("b_overrun_192", 1, 64'(last_ovr[1]), 64'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
